// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency burst memory between the I-cache (port 0) and D-cache (port 1).
// Build option MEM_ARB_RR_EN selects round-robin arbitration; otherwise port 1 has fixed priority.
module mem_port_arbiter #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned BEAT_W    = 3
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              P0_REQ,
    input  logic              P0_WE,
    input  logic [31:0]       P0_ADDR,
    input  logic [31:0]       P0_WDATA,
    output logic [31:0]       P0_RDATA,
    output logic              P0_VALID,
    output logic [BEAT_W-1:0] P0_BEAT,
    output logic              P0_DONE,

    input  logic              P1_REQ,
    input  logic              P1_WE,
    input  logic [31:0]       P1_ADDR,
    input  logic [31:0]       P1_WDATA,
    output logic [31:0]       P1_RDATA,
    output logic              P1_VALID,
    output logic [BEAT_W-1:0] P1_BEAT,
    output logic              P1_DONE,

    output logic              MEM_RE,
    output logic              MEM_WE,
    output logic [31:0]       MEM_ADDR,
    output logic [31:0]       MEM_DATA_IN,
    input  logic              MEM_VALID,
    input  logic [31:0]       MEM_DATA_OUT
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WADDR_W = 30;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic                 owner, owner_nxt;
    logic                 wr, wr_nxt;
    logic [WADDR_W-1:0]   base, base_nxt;
    logic [BEAT_W-1:0]    beat, beat_nxt;
    logic                 post_rst;
    logic                 grant_c;

    // Byte-offset bits of the line address carry no information for word bursts.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{P0_ADDR[1:0], P1_ADDR[1:0]};

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    // With both ports asking, hand the bus to whoever did not have it last.
    assign grant_c = (P0_REQ && P1_REQ) ? ~last_owner : P1_REQ;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_owner <= 1'b1;
        end else if (state == DONE) begin
            last_owner <= owner;
        end
    end
`else
    // Fixed priority: the D-cache wins whenever it asks.
    assign grant_c = P1_REQ;
`endif

    // State and transaction context registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            owner    <= 1'b0;
            wr       <= 1'b0;
            base     <= '0;
            beat     <= '0;
            post_rst <= 1'b1;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            wr       <= wr_nxt;
            base     <= base_nxt;
            beat     <= beat_nxt;
            post_rst <= 1'b0;
        end
    end

    // Next-state logic and memory/port outputs.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        wr_nxt      = wr;
        base_nxt    = base;
        beat_nxt    = beat;

        MEM_RE      = 1'b0;
        MEM_WE      = 1'b0;
        MEM_ADDR    = '0;
        MEM_DATA_IN = '0;
        P0_RDATA    = '0;
        P0_VALID    = 1'b0;
        P0_BEAT     = '0;
        P0_DONE     = 1'b0;
        P1_RDATA    = '0;
        P1_VALID    = 1'b0;
        P1_BEAT     = '0;
        P1_DONE     = 1'b0;

        case (state)
            IDLE: begin
                // The memory cannot be reset, so a burst still streaming after reset must be let through.
                if (post_rst && MEM_VALID) begin
                    state_nxt = DRAIN;
                end else if (P0_REQ || P1_REQ) begin
                    owner_nxt = grant_c;
                    wr_nxt    = grant_c ? P1_WE : P0_WE;
                    base_nxt  = grant_c ? P1_ADDR[ADDR_W-1:2] : P0_ADDR[ADDR_W-1:2];
                    beat_nxt  = '0;
                    state_nxt = BUSY;
                end
            end

            DRAIN: begin
                if (!MEM_VALID) begin
                    state_nxt = IDLE;
                end
            end

            BUSY: begin
                MEM_RE      = ~wr;
                MEM_WE      = wr;
                MEM_ADDR    = ADDR_W'(base) + ADDR_W'(beat);
                MEM_DATA_IN = owner ? P1_WDATA : P0_WDATA;
                if (owner) begin
                    P1_BEAT  = beat;
                    P1_VALID = MEM_VALID;
                    P1_RDATA = (MEM_VALID && !wr) ? MEM_DATA_OUT : '0;
                end else begin
                    P0_BEAT  = beat;
                    P0_VALID = MEM_VALID;
                    P0_RDATA = (MEM_VALID && !wr) ? MEM_DATA_OUT : '0;
                end
                // Latency cycles are not counted; only delivered beats advance the burst.
                if (MEM_VALID) begin
                    beat_nxt = beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                // RE/WE are already low here, which separates back-to-back bursts at the memory.
                P0_DONE   = ~owner;
                P1_DONE   = owner;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency burst memory model.
module tb_mem_port_arbiter;

    localparam int BURST_LEN = 8;
    localparam int BEAT_W    = 3;
    localparam int DELAY     = 10;

    logic              CLK;
    logic              RST_N;
    logic              P0_REQ, P0_WE;
    logic [31:0]       P0_ADDR, P0_WDATA, P0_RDATA;
    logic              P0_VALID, P0_DONE;
    logic [BEAT_W-1:0] P0_BEAT;
    logic              P1_REQ, P1_WE;
    logic [31:0]       P1_ADDR, P1_WDATA, P1_RDATA;
    logic              P1_VALID, P1_DONE;
    logic [BEAT_W-1:0] P1_BEAT;
    logic              MEM_RE, MEM_WE;
    logic [31:0]       MEM_ADDR, MEM_DATA_IN;
    logic              MEM_VALID = 1'b0;
    logic [31:0]       MEM_DATA_OUT = 32'h0;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.BURST_LEN(BURST_LEN), .BEAT_W(BEAT_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA),
        .P0_RDATA(P0_RDATA), .P0_VALID(P0_VALID), .P0_BEAT(P0_BEAT), .P0_DONE(P0_DONE),
        .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA),
        .P1_RDATA(P1_RDATA), .P1_VALID(P1_VALID), .P1_BEAT(P1_BEAT), .P1_DONE(P1_DONE),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA_IN(MEM_DATA_IN),
        .MEM_VALID(MEM_VALID), .MEM_DATA_OUT(MEM_DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Requesters present the word for the beat they are shown.
    assign P0_WDATA = 32'hB000 + 32'(P0_BEAT);
    assign P1_WDATA = 32'hA000 + 32'(P1_BEAT);

    // Memory: starts a burst when it sees RE/WE, waits DELAY cycles, then streams BURST_LEN beats.
    logic [31:0] mem [0:1023];
    bit          m_busy = 1'b0;
    bit          m_wr   = 1'b0;
    int          m_wait = 0;
    int          m_left = 0;
    logic [31:0] m_addr = 32'h0;

    always @(posedge CLK) begin
        #1;
        if (MEM_VALID) begin
            m_addr = m_addr + 32'd1;
            m_left = m_left - 1;
        end
        if (m_busy) begin
            if (m_wait > 0) begin
                m_wait    = m_wait - 1;
                MEM_VALID = 1'b0;
            end else if (m_left > 0) begin
                MEM_VALID    = 1'b1;
                MEM_DATA_OUT = mem[m_addr[9:0]];
            end else begin
                m_busy    = 1'b0;
                MEM_VALID = 1'b0;
            end
        end else if (MEM_RE || MEM_WE) begin
            m_busy    = 1'b1;
            m_wr      = MEM_WE;
            m_addr    = MEM_ADDR;
            m_wait    = DELAY - 1;
            m_left    = BURST_LEN;
            MEM_VALID = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (MEM_VALID && m_wr) mem[m_addr[9:0]] = MEM_DATA_IN;
    end

    typedef struct {
        logic        req0, req1, we0, we1;
        logic [31:0] addr0, addr1;
        logic        hold;
        int          drop_beat;
        int          exp_owner;
        logic        exp_wr;
        logic [31:0] exp_word0;
        logic [31:0] exp_rdata0;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic p_valid(input int p);
        return (p == 1) ? P1_VALID : P0_VALID;
    endfunction
    function automatic logic p_done(input int p);
        return (p == 1) ? P1_DONE : P0_DONE;
    endfunction
    function automatic logic [BEAT_W-1:0] p_beat(input int p);
        return (p == 1) ? P1_BEAT : P0_BEAT;
    endfunction
    function automatic logic [31:0] p_rdata(input int p);
        return (p == 1) ? P1_RDATA : P0_RDATA;
    endfunction

    // Apply one vector and follow its burst to the owner's DONE pulse.
    task automatic run_vec(input vec_t v, input int exp_pre, input int idx);
        int eo, no, beats, gap, pre;
        bit seen_active, finished;
        eo = v.exp_owner;
        no = 1 - eo;
        beats = 0; gap = 0; pre = 0;
        seen_active = 1'b0; finished = 1'b0;
        P0_REQ = v.req0; P0_WE = v.we0; P0_ADDR = v.addr0;
        P1_REQ = v.req1; P1_WE = v.we1; P1_ADDR = v.addr1;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            @(negedge CLK);
            chk($sformatf("v%0d other_valid", idx), 32'(p_valid(no)), 32'h0);
            chk($sformatf("v%0d other_done", idx), 32'(p_done(no)), 32'h0);
            chk($sformatf("v%0d other_beat", idx), 32'(p_beat(no)), 32'h0);
            if (MEM_RE || MEM_WE) begin
                seen_active = 1'b1;
                chk($sformatf("v%0d mem_we", idx), 32'(MEM_WE), 32'(v.exp_wr));
                chk($sformatf("v%0d mem_re", idx), 32'(MEM_RE), 32'(!v.exp_wr));
                chk($sformatf("v%0d mem_addr", idx), MEM_ADDR, v.exp_word0 + 32'(beats));
                if (MEM_VALID) begin
                    chk($sformatf("v%0d own_valid", idx), 32'(p_valid(eo)), 32'h1);
                    chk($sformatf("v%0d own_beat", idx), 32'(p_beat(eo)), 32'(beats));
                    if (!v.exp_wr)
                        chk($sformatf("v%0d rdata", idx), p_rdata(eo), v.exp_rdata0 + 32'(beats));
                    beats++;
                    if (beats == v.drop_beat) begin
                        if (eo == 1) P1_REQ = 1'b0;
                        else         P0_REQ = 1'b0;
                    end
                end else begin
                    if (beats == 0) gap++;
                    chk($sformatf("v%0d gap_valid", idx), 32'(p_valid(eo)), 32'h0);
                end
            end else if (!seen_active) begin
                pre++;
            end
            if (p_done(eo)) begin
                finished = 1'b1;
                chk($sformatf("v%0d done_re_we", idx), 32'({MEM_RE, MEM_WE}), 32'h0);
                chk($sformatf("v%0d beats", idx), 32'(beats), 32'(BURST_LEN));
                chk($sformatf("v%0d latency", idx), 32'(gap), 32'(DELAY));
                chk($sformatf("v%0d idle_cycles", idx), 32'(pre), 32'(exp_pre));
                if (!v.hold) begin
                    P0_REQ = 1'b0;
                    P1_REQ = 1'b0;
                end
            end
        end
        chk($sformatf("v%0d completed", idx), 32'(finished), 32'h1);
    endtask

    initial begin
        bit found, drained;

        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);

        // Fields: req0 req1 we0 we1 addr0 addr1 hold drop owner wr word0 rdata0
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h200, 1'b0, 8, 1, 1'b1, 32'h80, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,   1'b0, 8, 0, 1'b0, 32'h40, 32'h40};
`ifdef MEM_ARB_RR_EN
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b1, 8, 1, 1'b0, 32'h80, 32'hA000};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b1, 8, 0, 1'b0, 32'hC0, 32'hC0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b1, 8, 1, 1'b0, 32'h80, 32'hA000};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b0, 8, 0, 1'b0, 32'hC0, 32'hC0};
`else
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b1, 8, 1, 1'b0, 32'h80, 32'hA000};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b1, 8, 1, 1'b0, 32'h80, 32'hA000};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b1, 8, 1, 1'b0, 32'h80, 32'hA000};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 1'b0, 8, 1, 1'b0, 32'h80, 32'hA000};
`endif
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,   1'b1, 8, 0, 1'b0, 32'h40, 32'h40};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,   1'b0, 8, 0, 1'b0, 32'h40, 32'h40};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h140, 32'h0,   1'b0, 2, 0, 1'b0, 32'h50, 32'h50};

        RST_N = 1'b0;
        P0_REQ = 1'b0; P0_WE = 1'b0; P0_ADDR = 32'h0;
        P1_REQ = 1'b0; P1_WE = 1'b0; P1_ADDR = 32'h0;
        repeat (3) @(negedge CLK);
        chk("rst mem_re_we", 32'({MEM_RE, MEM_WE}), 32'h0);
        chk("rst mem_addr", MEM_ADDR, 32'h0);
        chk("rst mem_data_in", MEM_DATA_IN, 32'h0);
        chk("rst p0_rdata", P0_RDATA, 32'h0);
        chk("rst p1_rdata", P1_RDATA, 32'h0);
        chk("rst p0_flags", 32'({P0_VALID, P0_DONE, P0_BEAT}), 32'h0);
        chk("rst p1_flags", 32'({P1_VALID, P1_DONE, P1_BEAT}), 32'h0);
        RST_N = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], (i == 0) ? 0 : 1, i);

        for (int i = 0; i < BURST_LEN; i++)
            chk($sformatf("wr_mem[%0d]", 32'h80 + i), mem[32'h80 + i], 32'hA000 + 32'(i));

        // Reset in the middle of a read burst, with port 1 waiting.
        P0_REQ = 1'b1; P0_WE = 1'b0; P0_ADDR = 32'h100;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge CLK);
            if (P0_VALID && P0_BEAT == 3'd3) found = 1'b1;
        end
        chk("rst_mid beat3_reached", 32'(found), 32'h1);
        RST_N = 1'b0;
        P0_REQ = 1'b0;
        P1_REQ = 1'b1; P1_WE = 1'b0; P1_ADDR = 32'h200;
        @(negedge CLK);
        chk("rst_mid in_reset", 32'({MEM_RE, MEM_WE, P0_VALID, P1_VALID, P0_DONE, P1_DONE}), 32'h0);
        RST_N = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 50 && !drained; c++) begin
            @(negedge CLK);
            chk("drain silent", 32'({MEM_RE, MEM_WE, P0_VALID, P1_VALID, P0_DONE, P1_DONE}), 32'h0);
            if (!m_busy) drained = 1'b1;
        end
        chk("drain ended", 32'(drained), 32'h1);
        run_vec('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 1'b0, 8, 1, 1'b0, 32'h80, 32'hA000}, 1, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported, fixed-latency, burst main memory between two cache-line requesters: port 0 is the I-cache, port 1 is the D-cache.
- Picks a winner and drives MEM_RE/MEM_WE/MEM_ADDR/MEM_DATA_IN for one full burst.
- Steps the word address on every MEM_VALID beat and routes each beat back to the granted port.
- Sits between the two cache controllers and the memory.

Parameters:
- BURST_LEN, 8, words per transaction; must match the memory's burst length.
- BEAT_W, 3, width of the beat counter; equals clog2(BURST_LEN), minimum 1.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  synchronous reset, active-low.
- P0_REQ  in  1  port 0 line request; held until P0_DONE.
- P0_WE  in  1  port 0: 1 = line write, 0 = line read; stable while P0_REQ is high.
- P0_ADDR  in  32  port 0 line base byte address; bits [1:0] ignored.
- P0_WDATA  in  32  port 0 write word for the beat shown on P0_BEAT.
- P0_RDATA  out  32  read word for the current beat.
- P0_VALID  out  1  beat strobe for port 0.
- P0_BEAT  out  BEAT_W  current beat index.
- P0_DONE  out  1  one-cycle completion pulse.
- P1_*  same set as P0_*, for port 1.
- MEM_RE  out  1  memory read enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  32  memory word address.
- MEM_DATA_IN  out  32  memory write data.
- MEM_VALID  in  1  memory beat-valid strobe.
- MEM_DATA_OUT  in  32  memory read data.

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is synchronous and active-low.
- Reset values: state IDLE, beat=0, owner=0, last_owner=1. All outputs 0, except MEM_ADDR=0 and P*_RDATA=0.
- States: IDLE, DRAIN, BUSY, DONE.
- DRAIN (reset mid-burst):
  - Entered on reset release if MEM_VALID=1. Not entered from any other state.
  - Stays in DRAIN while MEM_VALID=1; goes to IDLE on the first edge where MEM_VALID=0.
  - No grants are issued while in DRAIN.
  - Required because the memory model cannot be reset and will finish any burst already in flight.
- IDLE: on an edge with any P*_REQ=1, latch the winner into owner, latch its WE and ADDR[31:2] into wr/base, clear beat, go to BUSY.
- Arbitration rule with both requesting: see Optional Feature.
- BUSY outputs:
  - MEM_RE = ~wr, MEM_WE = wr.
  - MEM_ADDR = base + beat (zero-extended word address, modulo 2^32).
  - MEM_DATA_IN = owner's WDATA.
  - Pn_BEAT = beat for the owner; non-owner's Pn_BEAT = 0.
- BUSY outputs to the owner only, all combinational on MEM_VALID:
  - Pn_VALID = MEM_VALID.
  - Pn_RDATA = MEM_DATA_OUT, valid on read beats only.
- BUSY beat counting:
  - On each edge with MEM_VALID=1, beat increments.
  - On the edge where MEM_VALID=1 and beat==BURST_LEN-1, go to DONE.
  - MEM_VALID=0 edges (the latency gap) leave beat unchanged.
  - Arbiter does not count latency cycles.
- Writes: the owner must present the word for the beat shown on Pn_BEAT combinationally. The memory samples it on the falling edge.
- DONE: one cycle. MEM_RE=MEM_WE=0; owner's Pn_DONE=1; last_owner<=owner; next state IDLE.
  - This guarantees RE/WE are low at the first edge after the burst, so back-to-back transactions never merge.
- Minimum gap: one DONE cycle plus one IDLE cycle between bursts.
- A requester dropping REQ mid-BUSY is ignored; the burst completes and DONE still pulses. REQ high during DONE is not regranted until IDLE.
- MEM_VALID in IDLE or DONE: ignored; no Pn_VALID is produced.
- Reset asserted in any state: next edge goes to IDLE with all outputs at reset values. DRAIN then applies as above.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration: with both requesting, grant the port != last_owner.
  - A single requester is always granted.
- Undefined:
  - Fixed priority: with both requesting, port 1 (D-cache) always wins.
  - last_owner is unused and may be optimized away.

Test Plan:
- Read burst:
  - Memory preloaded so word i holds i.
  - P0_REQ=1, P0_WE=0, P0_ADDR=0x100; memory delay 10, BURST_LEN 8.
  - Expect MEM_RE=1 and MEM_ADDR=0x40..0x47 on successive beats.
  - Expect P0_VALID for 8 cycles with P0_RDATA=0x40..0x47, then exactly one P0_DONE. P1_* stays idle.
- Write burst:
  - P1_REQ=1, P1_WE=1, P1_ADDR=0x200, P1_WDATA=0xA000+P1_BEAT.
  - After completion, memory words 0x80..0x87 must hold 0xA000..0xA007.
  - MEM_RE must stay 0 throughout.
- Simultaneous requests, both held for 4 transactions:
  - With MEM_ARB_RR_EN: grant order 1,0,1,0.
  - Without MEM_ARB_RR_EN: grant order 1,1,1,1 and port 0 starves.
- Back-to-back:
  - Port 0 re-raises REQ in the DONE cycle.
  - MEM_RE must be 0 on the edge after the last beat.
  - Second burst starts with its own full delay; no merged beats.
- Reset mid-burst:
  - Drive RST_N=0 for one cycle at beat 3 of a read, then release.
  - Arbiter must hold in DRAIN until MEM_VALID falls, then grant a pending P1_REQ.
  - No Pn_VALID or Pn_DONE may appear during DRAIN.
- Requester drops REQ:
  - P0_REQ deasserted at beat 2.
  - All 8 beats still complete and P0_DONE still pulses.
